image_mem_arbiter: RTL and testbench

Arbitrates the banked M10k image memory (240 banks × 480 words × 20 bits) between two requesters. The compute engine (port C) reads and writes. The HPS readback producer (port R) only reads. The block owns the single shared bank-select/address/write path and routes 1-cycle-latency read data back to whichever port issued the read. It uses round-robin ownership with a bounded burst length, an HPS priority override, and sticky out-of-range error reporting.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_range_check.sv | 12 +
 rtl/image_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_image_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared geometry and type definitions for the banked M10k image memory arbiter.
package mem_arb_pkg;

  localparam int N_BANKS = 240;
  localparam int DEPTH   = 480;
  localparam int DATA_W  = 20;
  localparam int ADDR_W  = 10;
  localparam int BANK_W  = 10;

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_R} owner_t;
  typedef enum logic       {PORT_C, PORT_R}     port_t;

endpackage

// File: rtl/mem_range_check.sv
// Flags whether a bank/word address lands inside the populated M10k array.
module mem_range_check
  import mem_arb_pkg::*;
(
  input  logic [BANK_W-1:0] bank,
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign in_range = (bank < BANK_W'(N_BANKS)) && (addr < ADDR_W'(DEPTH));

endmodule

// File: rtl/image_mem_arbiter.sv
// Round-robin arbiter with bounded bursts and HPS override between the compute
// engine (read/write) and the HPS readback producer (read only).
module image_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [BANK_W-1:0] c_bank,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              r_req,
  input  logic [BANK_W-1:0] r_bank,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_gnt,
  output logic              r_rvalid,
  output logic [DATA_W-1:0] r_rdata,
  input  logic              hps_priority,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clr,
  output logic              err_oob
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  owner_t           owner_q, owner_d;
  port_t            last_served_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_last;
  logic             in_range;
  logic             acc_gnt;
  logic             rd_gnt;
  logic             tag_valid;
  port_t            tag_port;
  logic             tag_oob;

  assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      IDLE: begin
        if (c_req && r_req)
          owner_d = (hps_priority || last_served_q == PORT_C) ? OWN_R : OWN_C;
        else if (c_req)
          owner_d = OWN_C;
        else if (r_req)
          owner_d = OWN_R;
      end
      OWN_C: begin
        if (!c_req)
          owner_d = r_req ? OWN_R : IDLE;
        else if (r_req && (hps_priority || burst_last))
          owner_d = OWN_R;
      end
      OWN_R: begin
        if (!r_req)
          owner_d = c_req ? OWN_C : IDLE;
        else if (c_req && burst_last)
          owner_d = OWN_C;
      end
      default: owner_d = IDLE;
    endcase
  end

  // The owner steers the single shared access path; outputs idle at zero.
  always_comb begin
    c_gnt     = 1'b0;
    r_gnt     = 1'b0;
    mem_bank  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner_q)
      OWN_C: begin
        c_gnt     = c_req;
        mem_bank  = c_bank;
        mem_addr  = c_addr;
        mem_wdata = c_wdata;
      end
      OWN_R: begin
        r_gnt     = r_req;
        mem_bank  = r_bank;
        mem_addr  = r_addr;
      end
      default: ;
    endcase
  end

  mem_range_check u_range (
    .bank     (mem_bank),
    .addr     (mem_addr),
    .in_range (in_range)
  );

  assign acc_gnt = c_gnt | r_gnt;
  assign rd_gnt  = (c_gnt & ~c_we) | r_gnt;
  assign mem_we  = c_gnt & c_we & in_range;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q       <= IDLE;
      last_served_q <= PORT_R;
      burst_cnt     <= '0;
      tag_valid     <= 1'b0;
      tag_port      <= PORT_C;
      tag_oob       <= 1'b0;
      err_oob       <= 1'b0;
    end else begin
      owner_q <= owner_d;
      if (owner_d != owner_q && owner_q != IDLE)
        last_served_q <= (owner_q == OWN_C) ? PORT_C : PORT_R;
      // Saturating count: a long solo owner yields at once when contention appears.
      if (owner_d != owner_q)
        burst_cnt <= '0;
      else if (acc_gnt && !burst_last)
        burst_cnt <= burst_cnt + 1'b1;
      tag_valid <= rd_gnt;
      tag_port  <= r_gnt ? PORT_R : PORT_C;
      tag_oob   <= ~in_range;
      if (acc_gnt && !in_range)
        err_oob <= 1'b1;
      else if (err_clr)
        err_oob <= 1'b0;
    end
  end

  assign c_rvalid = tag_valid && (tag_port == PORT_C);
  assign r_rvalid = tag_valid && (tag_port == PORT_R);
  assign c_rdata  = (c_rvalid && !tag_oob) ? mem_rdata : '0;
  assign r_rdata  = (r_rvalid && !tag_oob) ? mem_rdata : '0;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Scoreboard bench for image_mem_arbiter: directed stimulus pushes expected read
// returns, a negedge monitor matches them against rvalid/rdata with exact latency.
module tb_image_mem_arbiter;
  import mem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [BANK_W-1:0] c_bank;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              r_req, r_gnt, r_rvalid;
  logic [BANK_W-1:0] r_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              hps_priority;
  logic [BANK_W-1:0] mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              err_clr, err_oob;

  always #5 clk = ~clk;

  image_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_bank(c_bank), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .r_req(r_req), .r_bank(r_bank), .r_addr(r_addr),
    .r_gnt(r_gnt), .r_rvalid(r_rvalid), .r_rdata(r_rdata),
    .hps_priority(hps_priority),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .err_clr(err_clr), .err_oob(err_oob)
  );

  // Memory model: registered read, out-of-range reads return a poison value.
  logic [DATA_W-1:0] mem [N_BANKS][DEPTH];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[0][0] <= 20'h00011;
      mem[0][1] <= 20'h00022;
      mem[0][2] <= 20'h00033;
    end else if (mem_we && mem_bank < 10'd240 && mem_addr < 10'd480) begin
      mem[mem_bank][mem_addr] <= mem_wdata;
    end
    if (mem_bank < 10'd240 && mem_addr < 10'd480)
      mem_rdata <= mem[mem_bank][mem_addr];
    else
      mem_rdata <= 20'hBAD00;
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t c_q[$];
  exp_t r_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_c(input logic [DATA_W-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc;
    c_q.push_back(e);
  endtask

  task automatic push_r(input logic [DATA_W-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc;
    r_q.push_back(e);
  endtask

  // Monitor: an rvalid must appear exactly one cycle after each pushed read grant and nowhere else.
  always @(negedge clk) begin
    logic due;
    exp_t e;
    due = (c_q.size() != 0) && (c_q[0].cyc + 1 == cyc);
    check("c_rvalid", 32'(c_rvalid), 32'(due));
    if (due) begin
      e = c_q.pop_front();
      if (c_rvalid) check("c_rdata", 32'(c_rdata), 32'(e.data));
    end
    due = (r_q.size() != 0) && (r_q[0].cyc + 1 == cyc);
    check("r_rvalid", 32'(r_rvalid), 32'(due));
    if (due) begin
      e = r_q.pop_front();
      if (r_rvalid) check("r_rdata", 32'(r_rdata), 32'(e.data));
    end
  end

  task automatic clr_inputs();
    c_req = 0; c_we = 0; c_bank = '0; c_addr = '0; c_wdata = '0;
    r_req = 0; r_bank = '0; r_addr = '0;
    hps_priority = 0; err_clr = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic gnt_chk(input string n, input logic ec, input logic er);
    @(negedge clk);
    check({n, "_c_gnt"}, 32'(c_gnt), 32'(ec));
    check({n, "_r_gnt"}, 32'(r_gnt), 32'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] solo_exp [3] = '{20'h00011, 20'h00022, 20'h00033};

  initial begin
    clr_inputs();
    reset = 1;
    repeat (3) next();
    @(negedge clk);
    check("rst_c_gnt", 32'(c_gnt), 0);
    check("rst_r_gnt", 32'(r_gnt), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_err_oob", 32'(err_oob), 0);
    check("rst_mem_bank", 32'(mem_bank), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_c_rdata", 32'(c_rdata), 0);
    check("rst_r_rdata", 32'(r_rdata), 0);
    next();
    reset = 0;

    // Solo R: one bubble, then three back-to-back reads.
    r_req = 1;
    gnt_chk("solo_bubble", 0, 0);
    next();
    for (int i = 0; i < 3; i++) begin
      r_addr = 10'(i);
      gnt_chk("solo_rd", 0, 1);
      check("solo_mem_addr", 32'(mem_addr), 32'(i));
      push_r(solo_exp[i]);
      next();
    end
    clr_inputs();
    repeat (2) next();

    // Contention from reset: bubble, C x4, R x4, C x4 with no gaps.
    reset = 1;
    c_req = 1; c_we = 1; c_bank = 10'd1; c_addr = '0; c_wdata = 20'h55555;
    r_req = 1; r_bank = '0; r_addr = '0;
    repeat (2) next();
    reset = 0;
    for (int k = 0; k < 13; k++) begin
      logic ec, er;
      ec = (k >= 1 && k <= 4) || (k >= 9 && k <= 12);
      er = (k >= 5 && k <= 8);
      gnt_chk($sformatf("cont%0d", k), ec, er);
      if (ec) check("cont_mem_we", 32'(mem_we), 1);
      if (er) push_r(20'h00011);
      next();
    end
    clr_inputs();
    repeat (2) next();

    // Override: R with hps_priority preempts C after its second grant.
    c_req = 1; c_bank = '0; c_addr = 10'd1;
    gnt_chk("ovr_bubble", 0, 0);
    next();
    gnt_chk("ovr_c0", 1, 0);
    push_c(20'h00022);
    next();
    r_req = 1; hps_priority = 1; r_addr = 10'd2;
    gnt_chk("ovr_c1", 1, 0);
    push_c(20'h00022);
    next();
    gnt_chk("ovr_r", 0, 1);
    push_r(20'h00033);
    next();
    clr_inputs();
    repeat (2) next();

    // Out-of-range write: granted, write suppressed, sticky error until err_clr.
    c_req = 1; c_we = 1; c_bank = 10'd240; c_addr = '0; c_wdata = 20'h12345;
    gnt_chk("oob_bubble", 0, 0);
    next();
    gnt_chk("oob_wr", 1, 0);
    check("oob_mem_we", 32'(mem_we), 0);
    check("oob_err_before", 32'(err_oob), 0);
    next();
    c_req = 0; c_we = 0;
    @(negedge clk);
    check("oob_err_set", 32'(err_oob), 1);
    next();
    @(negedge clk);
    check("oob_err_held", 32'(err_oob), 1);
    next();
    err_clr = 1;
    @(negedge clk);
    check("oob_err_in_clr", 32'(err_oob), 1);
    next();
    err_clr = 0;
    @(negedge clk);
    check("oob_err_cleared", 32'(err_oob), 0);
    next();

    // Out-of-range read together with err_clr: data is zero and the set wins.
    c_req = 1; c_bank = '0; c_addr = 10'd480;
    gnt_chk("oobr_bubble", 0, 0);
    next();
    err_clr = 1;
    gnt_chk("oobr_rd", 1, 0);
    push_c(20'h00000);
    next();
    err_clr = 0; c_req = 0;
    @(negedge clk);
    check("oobr_set_wins", 32'(err_oob), 1);
    next();
    err_clr = 1;
    next();
    err_clr = 0;
    @(negedge clk);
    check("oobr_cleared", 32'(err_oob), 0);
    next();

    // Coherence: C writes the last word, R reads it back.
    c_req = 1; c_we = 1; c_bank = 10'd239; c_addr = 10'd479; c_wdata = 20'hABCDE;
    gnt_chk("coh_bubble", 0, 0);
    next();
    gnt_chk("coh_wr", 1, 0);
    check("coh_mem_we", 32'(mem_we), 1);
    check("coh_mem_wdata", 32'(mem_wdata), 32'h000ABCDE);
    next();
    c_req = 0; c_we = 0;
    r_req = 1; r_bank = 10'd239; r_addr = 10'd479;
    gnt_chk("coh_handoff", 0, 0);
    next();
    gnt_chk("coh_rd", 0, 1);
    push_r(20'hABCDE);
    next();
    clr_inputs();
    repeat (2) next();

    // Reset in the cycle of an R read grant drops the return tag.
    r_req = 1; r_addr = 10'd2;
    gnt_chk("rst_bubble", 0, 0);
    next();
    gnt_chk("rst_rd", 0, 1);
    reset = 1;
    next();
    reset = 0;
    gnt_chk("rst_after", 0, 0);
    check("rst_after_rvalid", 32'(r_rvalid), 0);
    check("rst_after_mem_addr", 32'(mem_addr), 0);
    next();
    gnt_chk("rst_regrant", 0, 1);
    push_r(20'h00033);
    next();
    clr_inputs();
    repeat (3) next();

    @(negedge clk);
    check("c_q_drained", 32'(c_q.size()), 0);
    check("r_q_drained", 32'(r_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
